// File: rtl/data_ram_lsu.sv
// Single-port data RAM with a RISC-V style load/store front end.
// Byte/half/word/double accesses, byte-lane writes, sign/zero-extended loads,
// misalignment reporting and a fixed-latency in-order response pipeline.
// The array clears itself word by word after reset before accepting requests.
// Supported configurations: DATA_WIDTH 32 or 64, RD_LATENCY 1..4.
module data_ram_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - OFFS;
  localparam int DEPTH = 2 ** IW;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Low 2**size bytes enabled, before shifting into the addressed lane.
  function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << size)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Truncate a right-aligned load to 2**size bytes and extend to full width.
  // Full-width (or wider) sizes pass through untouched.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] r;
    logic                  s;
    r = d;
    s = 1'b0;
    if (int'(size) < OFFS) begin
      for (int i = 0; i < NB; i++) begin
        if (i == (1 << size) - 1) s = ~uns & d[8*i+7];
      end
      for (int i = 0; i < NB; i++) begin
        if (i >= (1 << size)) r[8*i +: 8] = s ? 8'hFF : 8'h00;
      end
    end
    return r;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  init_we;
  logic                  st_we;
  logic [IW-1:0]         widx;
  logic [OFFS-1:0]       lane;
  logic [ADDR_WIDTH-1:0] amask;
  logic                  req_err;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] wr_word;

  logic [RD_LATENCY-1:0] vld_p_q, vld_p_d;
  logic [RD_LATENCY-1:0] err_p_q, err_p_d;
  logic [RD_LATENCY-1:0] uns_p_q, uns_p_d;
  logic [1:0]            size_p_q [RD_LATENCY];
  logic [1:0]            size_p_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_p_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_p_d [RD_LATENCY];

  // Init sequencer: sweep the array once, then stay ready until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(DEPTH - 1)) state_d = ST_READY;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_READY);
  assign accept    = req_valid & req_ready & rst_n;
  assign init_we   = rst_n & (state_q == ST_INIT);

  // Request decode: word index, lane, alignment check and lane-shifted data.
  always_comb begin
    widx     = req_addr[ADDR_WIDTH-1:OFFS];
    lane     = req_addr[OFFS-1:0];
    amask    = ADDR_WIDTH'((32'd1 << req_size) - 32'd1);
    req_err  = (int'(req_size) > OFFS) || ((req_addr & amask) != '0);
    be       = size_mask(req_size) << lane;
    wdata_sh = req_wdata << {lane, 3'b000};
    rd_sh    = mem[widx] >> {lane, 3'b000};
    st_we    = accept & req_we & ~req_err;
  end

  // Merge enabled store bytes into the currently stored word.
  always_comb begin
    wr_word = mem[widx];
    for (int b = 0; b < NB; b++) begin
      if (be[b]) wr_word[8*b +: 8] = wdata_sh[8*b +: 8];
    end
  end

  // Storage: init sweep has priority; stores only once ready.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[cnt_q] <= '0;
    end else if (st_we) begin
      mem[widx] <= wr_word;
    end
  end

  // Response pipeline next-state: stage 0 captures the access, later stages shift.
  always_comb begin
    // p0: capture at the accepting edge
    vld_p_d[0]  = accept;
    err_p_d[0]  = req_err;
    uns_p_d[0]  = req_unsigned;
    size_p_d[0] = req_size;
    data_p_d[0] = (accept & ~req_we & ~req_err) ? rd_sh : '0;
    // p1..pN: pure delay stages
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_p_d[i]  = vld_p_q[i-1];
      err_p_d[i]  = err_p_q[i-1];
      uns_p_d[i]  = uns_p_q[i-1];
      size_p_d[i] = size_p_q[i-1];
      data_p_d[i] = data_p_q[i-1];
    end
  end

  // Pipeline registers: only the valid bits are reset; payload follows valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p_q <= '0;
    end else begin
      vld_p_q <= vld_p_d;
    end
    err_p_q  <= err_p_d;
    uns_p_q  <= uns_p_d;
    size_p_q <= size_p_d;
    data_p_q <= data_p_d;
  end

  // Final stage: extension and zeroing of outputs when no response is due.
  always_comb begin
    rsp_valid = vld_p_q[RD_LATENCY-1];
    rsp_err   = vld_p_q[RD_LATENCY-1] & err_p_q[RD_LATENCY-1];
    rsp_rdata = '0;
    if (vld_p_q[RD_LATENCY-1]) begin
      rsp_rdata = load_extend(data_p_q[RD_LATENCY-1], size_p_q[RD_LATENCY-1],
                              uns_p_q[RD_LATENCY-1]);
    end
  end

endmodule
